pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter: n, default 32, datapath/address width in bits.
REQ-002 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: redirect_valid  input  1  taken branch/jump request this cycle.
REQ-006 Port: redirect_pc  input  n  branch/jump target address.
REQ-007 Port: imem_req  output  1  instruction-memory read request.
REQ-008 Port: imem_addr  output  n  instruction-memory read address.
REQ-009 Port: imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-010 Port: imem_rdata  input  32  instruction word from memory.
REQ-011 Port: if_valid  output  1  fetched instruction available to decode.
REQ-012 Port: if_ready  input  1  decode accepts the instruction this cycle.
REQ-013 Port: if_instr  output  32  fetched instruction.
REQ-014 Port: if_pc  output  n  address of if_instr.
REQ-015 Port: if_pcplus4  output  n  if_pc + 4, sequential successor fed to the branch-target adder.

Function
REQ-016 FSM states: IDLE, REQ, HOLD; IDLE goes to REQ unconditionally on the first clock after reset release.
REQ-017 In REQ, imem_req=1 and imem_addr=pc; both held stable until imem_ack or redirect.
REQ-018 REQ with imem_ack=1 and no redirect: capture if_instr=imem_rdata, if_pc=pc, if_pcplus4=pc+4; pc<=pc+4; go to HOLD with if_valid=1 the next cycle.
REQ-019 A same-cycle ack is legal; minimum REQ duration is one cycle.
REQ-020 In HOLD, imem_req=0 and if_valid=1; if_instr, if_pc, if_pcplus4 hold stable while if_ready=0.
REQ-021 HOLD with if_ready=1: go to REQ; if_valid=0 the next cycle. Peak throughput is one instruction per 2 cycles.
REQ-022 PC increment is an n-bit modular sum with carry discarded: pc 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-023 Redirect in any state: pc<=redirect_pc with bits [1:0] forced to 00; if_valid<=0; next state is REQ.
REQ-024 Redirect takes priority over a simultaneous imem_ack; the returned word is discarded and the PC does not increment.
REQ-025 Redirect takes priority over a simultaneous if_ready in HOLD. The held instruction counts as consumed, and the PC becomes the target.
REQ-026 Redirect in IDLE takes effect; the first request uses the redirected address.
REQ-027 imem_ack outside REQ is ignored.

Reset
REQ-028 rst_n=0 asynchronously forces: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pcplus4=0.
REQ-029 Reset asserted mid-transaction, including an outstanding REQ, abandons the transaction; a late imem_ack after release is ignored unless the block is in REQ.

Configuration
REQ-030 Macro PC_FETCH_PERF_EN defined: adds output port stall_cycles (32 bits, reset 0).
REQ-031 stall_cycles increments once per cycle in REQ with imem_ack=0, or in HOLD with if_ready=0; it saturates at 32'hFFFF_FFFF.
REQ-032 Macro undefined: the port and counter are absent, and all other behaviour is identical.

Verification
REQ-033 Reset release, imem_ack tied 1, if_ready tied 1 -> imem_addr sequence 0,4,8,C on every other cycle; if_pcplus4 = if_pc+4.
REQ-034 RESET_PC=32'hFFFF_FFFC, ack=1, ready=1 -> first if_pc=FFFF_FFFC, if_pcplus4=0, next imem_addr=0.
REQ-035 HOLD with if_ready=0 for 5 cycles -> if_valid, if_instr, if_pc stable; imem_req=0; with PC_FETCH_PERF_EN, stall_cycles=5.
REQ-036 In REQ, redirect_valid=1, redirect_pc=32'h0000_0103, imem_ack=1 in the same cycle -> data discarded, if_valid=0, next imem_addr=32'h0000_0100.
REQ-037 Assert rst_n=0 mid-REQ for 1 ns between clock edges -> all outputs at reset values immediately; after release, the first imem_addr equals RESET_PC.

Source files
------------

// File: rtl/pc_fetch.sv
// pc_fetch: program-counter and instruction-fetch front end.
// Issues one instruction-memory read at a time, hands the returned word to
// decode with a valid/ready handshake, and follows branch/jump redirects.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   redirect_valid    taken branch/jump this cycle
//   redirect_pc       branch/jump target (bits [1:0] are ignored)
//   imem_req          read request to instruction memory
//   imem_addr         read address (equals the current PC)
//   imem_ack          memory returns imem_rdata this cycle
//   imem_rdata        instruction word from memory
//   if_valid          fetched instruction available to decode
//   if_ready          decode accepts the instruction this cycle
//   if_instr          fetched instruction
//   if_pc             address of if_instr
//   if_pcplus4        if_pc + 4
//   stall_cycles      (only with PC_FETCH_PERF_EN) saturating stall counter
//
// Optional feature: define PC_FETCH_PERF_EN to add the stall_cycles counter.
module pc_fetch #(
    parameter int unsigned    n        = 32,
    parameter logic [n-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          redirect_valid,
    input  logic [n-1:0]  redirect_pc,
    output logic          imem_req,
    output logic [n-1:0]  imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic          if_valid,
    input  logic          if_ready,
    output logic [31:0]   if_instr,
    output logic [n-1:0]  if_pc,
    output logic [n-1:0]  if_pcplus4
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [31:0]   stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state;
    logic [n-1:0]   pc;
    logic [n-1:0]   pc_plus4;
    logic [n-1:0]   redirect_tgt;

    // Carry out of the increment is dropped, so the PC wraps modulo 2^n.
    assign pc_plus4     = pc + n'(4);
    assign redirect_tgt = {redirect_pc[n-1:2], 2'b00};

    // The PC register itself drives the memory address, so the address is
    // held stable for as long as the request is outstanding.
    assign imem_addr = pc;

    // Fetch FSM with registered outputs. Redirect overrides everything,
    // discarding any word returned or held in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
            if_pcplus4 <= '0;
        end else if (redirect_valid) begin
            state    <= REQ;
            pc       <= redirect_tgt;
            imem_req <= 1'b1;
            if_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_ack) begin
                        if_instr   <= imem_rdata;
                        if_pc      <= pc;
                        if_pcplus4 <= pc_plus4;
                        pc         <= pc_plus4;
                        state      <= HOLD;
                        imem_req   <= 1'b0;
                        if_valid   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (if_ready) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                        if_valid <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_FETCH_PERF_EN
    logic stall;

    // A stall is a cycle waiting on memory or waiting on decode.
    assign stall = ((state == REQ)  && !imem_ack) ||
                   ((state == HOLD) && !if_ready);

    // Saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed self-checking bench for pc_fetch.
// dut0 uses the default reset PC, dut1 resets to 32'hFFFF_FFFC; both share
// all inputs.
module tb_pc_fetch;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_ready;

    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic        valid0, valid1;
    logic [31:0] instr0, instr1;
    logic [31:0] ifpc0, ifpc1;
    logic [31:0] p4_0, p4_1;
`ifdef PC_FETCH_PERF_EN
    logic [31:0] stall0, stall1;
`endif

    int checks   = 0;
    int failures = 0;

    pc_fetch #(.n(32), .RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(req0), .imem_addr(addr0),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(valid0), .if_ready(if_ready),
        .if_instr(instr0), .if_pc(ifpc0), .if_pcplus4(p4_0)
`ifdef PC_FETCH_PERF_EN
        , .stall_cycles(stall0)
`endif
    );

    pc_fetch #(.n(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(req1), .imem_addr(addr1),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(valid1), .if_ready(if_ready),
        .if_instr(instr1), .if_pc(ifpc1), .if_pcplus4(p4_1)
`ifdef PC_FETCH_PERF_EN
        , .stall_cycles(stall1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] held;

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = 1'b1;
        imem_rdata     = 32'h0;
        if_ready       = 1'b1;

        // Reset values
        #12;
        chk("rst_req",    32'(req0),   32'h0);
        chk("rst_addr0",  addr0,       32'h0);
        chk("rst_addr1",  addr1,       32'hFFFF_FFFC);
        chk("rst_valid",  32'(valid0), 32'h0);
        chk("rst_instr",  instr0,      32'h0);
        chk("rst_ifpc1",  ifpc1,       32'h0);
        chk("rst_p4_1",   p4_1,        32'h0);
        rst_n = 1'b1;

        // Back-to-back fetch with ack and ready tied high: 0,4,8,C
        for (int k = 0; k < 4; k++) begin
            imem_rdata = 32'hA000_0000 + 32'(k);
            tick;
            chk($sformatf("seq%0d_req", k),   32'(req0),   32'h1);
            chk($sformatf("seq%0d_addr", k),  addr0,       32'(4 * k));
            chk($sformatf("seq%0d_vld0", k),  32'(valid0), 32'h0);
            if (k == 1) chk("wrap_addr1", addr1, 32'h0000_0000);
            tick;
            chk($sformatf("seq%0d_vld1", k),  32'(valid0), 32'h1);
            chk($sformatf("seq%0d_hreq", k),  32'(req0),   32'h0);
            chk($sformatf("seq%0d_ifpc", k),  ifpc0,       32'(4 * k));
            chk($sformatf("seq%0d_p4", k),    p4_0,        32'(4 * k + 4));
            chk($sformatf("seq%0d_instr", k), instr0,      32'hA000_0000 + 32'(k));
            if (k == 0) begin
                chk("wrap_ifpc1", ifpc1, 32'hFFFF_FFFC);
                chk("wrap_p4_1",  p4_1,  32'h0000_0000);
            end
        end

        // HOLD with decode stalled for 5 cycles
        if_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("hold_valid", 32'(valid0), 32'h1);
            chk("hold_req",   32'(req0),   32'h0);
            chk("hold_instr", instr0,      32'hA000_0003);
            chk("hold_ifpc",  ifpc0,       32'h0000_000C);
        end
`ifdef PC_FETCH_PERF_EN
        chk("stall_cnt", stall0, 32'd5);
`endif
        if_ready = 1'b1;
        tick;
        chk("rel_req",   32'(req0),   32'h1);
        chk("rel_addr",  addr0,       32'h0000_0010);
        chk("rel_valid", 32'(valid0), 32'h0);

        // Redirect beats a same-cycle ack in REQ
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        imem_rdata     = 32'hDEAD_BEEF;
        tick;
        chk("rdr_addr",  addr0,       32'h0000_0100);
        chk("rdr_valid", 32'(valid0), 32'h0);
        chk("rdr_req",   32'(req0),   32'h1);
        chk("rdr_instr", instr0,      32'hA000_0003);
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        tick;
        tick;
        chk("wait_addr", addr0,     32'h0000_0100);
        chk("wait_req",  32'(req0), 32'h1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h5555_0001;
        tick;
        chk("tgt_valid", 32'(valid0), 32'h1);
        chk("tgt_ifpc",  ifpc0,       32'h0000_0100);
        chk("tgt_p4",    p4_0,        32'h0000_0104);
        chk("tgt_instr", instr0,      32'h5555_0001);

        // Ack outside REQ is ignored while decode stalls
        if_ready   = 1'b0;
        imem_rdata = 32'h7777_7777;
        tick;
        chk("hack_instr", instr0, 32'h5555_0001);
        chk("hack_ifpc",  ifpc0,  32'h0000_0100);

        // Redirect beats a same-cycle if_ready in HOLD
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        tick;
        chk("hrdr_addr",  addr0,       32'h0000_2000);
        chk("hrdr_valid", 32'(valid0), 32'h0);
        chk("hrdr_req",   32'(req0),   32'h1);
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;

        // Asynchronous reset pulse in the middle of an outstanding REQ
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_req",   32'(req0),   32'h0);
        chk("arst_addr",  addr0,       32'h0);
        chk("arst_addr1", addr1,       32'hFFFF_FFFC);
        chk("arst_valid", 32'(valid0), 32'h0);
        chk("arst_instr", instr0,      32'h0);
        chk("arst_ifpc",  ifpc0,       32'h0);
        chk("arst_p4",    p4_0,        32'h0);
        rst_n = 1'b1;
        // Late ack arrives while in IDLE and must not capture data
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        tick;
        chk("post_req",   32'(req0),   32'h1);
        chk("post_addr",  addr0,       32'h0);
        chk("post_valid", 32'(valid0), 32'h0);
        chk("post_instr", instr0,      32'h0);
        imem_rdata = 32'h1234_5678;
        tick;
        chk("post_ifpc",  ifpc0,  32'h0);
        chk("post_instr2", instr0, 32'h1234_5678);

        // Redirect presented in IDLE sets the first request address
        rst_n          = 1'b0;
        #2;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3001;
        rst_n          = 1'b1;
        tick;
        held = addr0;
        chk("idle_rdr_addr", held,      32'h0000_3000);
        chk("idle_rdr_req",  32'(req0), 32'h1);
        redirect_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
